// File: rtl/sprite_compositor_if.sv
// Bus bundle between the sprite compositor, the game logic, the sprite ROM
// and the VGA adapter. The master modport is the compositor side.
interface sprite_compositor_if #(
   parameter int N_CH = 2,
   parameter int X_W  = 9,
   parameter int Y_W  = 8,
   parameter int S_W  = 6
);
   logic                start;
   logic [N_CH-1:0]     ch_en;
   logic [N_CH*X_W-1:0] ch_x;
   logic [N_CH*Y_W-1:0] ch_y;
   logic [N_CH*S_W-1:0] ch_w;
   logic [N_CH*S_W-1:0] ch_h;
   logic [2:0]          rom_ch;
   logic [S_W-1:0]      rom_dx;
   logic [S_W-1:0]      rom_dy;
   logic [2:0]          rom_colour;
   logic                plot;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [2:0]          colour;
   logic                busy;
   logic                done;
   logic [N_CH-1:0]     hit;

   modport master (
      input  start, ch_en, ch_x, ch_y, ch_w, ch_h, rom_colour,
      output rom_ch, rom_dx, rom_dy, plot, x, y, colour, busy, done, hit
   );

   modport slave (
      output start, ch_en, ch_x, ch_y, ch_w, ch_h, rom_colour,
      input  rom_ch, rom_dx, rom_dy, plot, x, y, colour, busy, done, hit
   );
endinterface

// File: rtl/sprite_compositor.sv
// N-channel sprite renderer: on each start pulse it erases moved/disabled
// sprites with the background colour, redraws every enabled sprite from a
// shared synchronous ROM (transparent and off-screen pixels are not plotted)
// and finally registers pairwise bounding-box overlap flags.
module sprite_compositor #(
   parameter int         N_CH          = 2,
   parameter int         X_W           = 9,
   parameter int         Y_W           = 8,
   parameter int         S_W           = 6,
   parameter int         SCREEN_W      = 320,
   parameter int         SCREEN_H      = 240,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter bit         TRANSP_EN     = 1'b1,
   parameter logic [2:0] TRANSP_COLOUR = 3'b101
) (
   input logic                 clock,
   input logic                 resetn,
   sprite_compositor_if.master bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ERASE   = 3'd1;
   localparam logic [2:0] S_DRAW    = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_COLLIDE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

   // control
   logic [2:0]          r_state;
   logic [N_CH-1:0]     r_emask;
   logic [N_CH-1:0]     r_dmask;
   logic [N_CH-1:0]     r_ovalid;
   logic [N_CH-1:0]     r_hit;
   logic [S_W-1:0]      r_dx_p0;
   logic [S_W-1:0]      r_dy_p0;
   logic [2:0]          r_rom_ch;
   logic [S_W-1:0]      r_rom_dx;
   logic [S_W-1:0]      r_rom_dy;
   logic                r_vld_p1;

   // snapshot and previous-pass boxes
   logic [N_CH-1:0]     r_sen;
   logic [N_CH*X_W-1:0] r_sx, r_ox;
   logic [N_CH*Y_W-1:0] r_sy, r_oy;
   logic [N_CH*S_W-1:0] r_sw, r_sh, r_ow, r_oh;

   // pixel pipeline
   logic [X_W-1:0]      r_x_p1;
   logic [Y_W-1:0]      r_y_p1;
   logic                r_plot_p2;
   logic [X_W-1:0]      r_x_p2;
   logic [Y_W-1:0]      r_y_p2;
   logic [2:0]          r_colour_p2;

   logic [N_CH-1:0]     w_emask_start;
   logic [N_CH-1:0]     w_mask_cur;
   logic [N_CH-1:0]     w_mask_next;
   logic [N_CH-1:0]     w_hit;
   logic [2:0]          w_ch;
   logic [X_W-1:0]      w_bx;
   logic [Y_W-1:0]      w_by;
   logic [S_W-1:0]      w_bw;
   logic [S_W-1:0]      w_bh;
   logic [X_W:0]        w_px;
   logic [Y_W:0]        w_py;
   logic                w_on_screen;
   logic                w_last_dx;
   logic                w_last_dy;

   function automatic logic [2:0] lowest(input logic [N_CH-1:0] m);
      logic [2:0] idx;
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i]) idx = 3'(i);
      return idx;
   endfunction

   // Pixel clipping at extended width so right/bottom overflow never wraps.
   function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
      return (px < SCR_W) && (py < SCR_H);
   endfunction

   function automatic logic overlap(input int i, input int j);
      logic [X_W:0] xi, xj, xie, xje;
      logic [Y_W:0] yi, yj, yie, yje;
      xi  = {1'b0, r_sx[i*X_W +: X_W]};
      xj  = {1'b0, r_sx[j*X_W +: X_W]};
      yi  = {1'b0, r_sy[i*Y_W +: Y_W]};
      yj  = {1'b0, r_sy[j*Y_W +: Y_W]};
      xie = xi + (X_W+1)'(r_sw[i*S_W +: S_W]);
      xje = xj + (X_W+1)'(r_sw[j*S_W +: S_W]);
      yie = yi + (Y_W+1)'(r_sh[i*S_W +: S_W]);
      yje = yj + (Y_W+1)'(r_sh[j*S_W +: S_W]);
      return (xi <= xje) && (xj <= xie) && (yi <= yje) && (yj <= yie);
   endfunction

   // A channel needs erasing when its last drawn box is live and it moved or was disabled
   always_comb begin
      w_emask_start = '0;
      for (int i = 0; i < N_CH; i++)
         w_emask_start[i] = r_ovalid[i] &&
                            ((bus.ch_x[i*X_W +: X_W] != r_ox[i*X_W +: X_W]) ||
                             (bus.ch_y[i*Y_W +: Y_W] != r_oy[i*Y_W +: Y_W]) ||
                             !bus.ch_en[i]);
   end

   assign w_mask_cur  = (r_state == S_ERASE) ? r_emask : r_dmask;
   assign w_ch        = lowest(w_mask_cur);
   assign w_mask_next = w_mask_cur & ~(N_CH'(1) << w_ch);

   // Box being scanned: old box while erasing, snapshot box while drawing
   always_comb begin
      if (r_state == S_ERASE) begin
         w_bx = r_ox[w_ch*X_W +: X_W];
         w_by = r_oy[w_ch*Y_W +: Y_W];
         w_bw = r_ow[w_ch*S_W +: S_W];
         w_bh = r_oh[w_ch*S_W +: S_W];
      end else begin
         w_bx = r_sx[w_ch*X_W +: X_W];
         w_by = r_sy[w_ch*Y_W +: Y_W];
         w_bw = r_sw[w_ch*S_W +: S_W];
         w_bh = r_sh[w_ch*S_W +: S_W];
      end
   end

   assign w_px        = {1'b0, w_bx} + (X_W+1)'(r_dx_p0);
   assign w_py        = {1'b0, w_by} + (Y_W+1)'(r_dy_p0);
   assign w_on_screen = on_screen(w_px, w_py);
   assign w_last_dx   = (r_dx_p0 == w_bw);
   assign w_last_dy   = (r_dy_p0 == w_bh);

   // Pairwise overlap of enabled snapshot boxes
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_CH; i++)
         for (int j = 0; j < N_CH; j++)
            if (i != j && r_sen[i] && r_sen[j] && overlap(i, j)) w_hit[i] = 1'b1;
   end

   // Pass sequencing: channel masks, raster counters and ROM address hold
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_emask  <= '0;
         r_dmask  <= '0;
         r_ovalid <= '0;
         r_hit    <= '0;
         r_dx_p0  <= '0;
         r_dy_p0  <= '0;
         r_rom_ch <= '0;
         r_rom_dx <= '0;
         r_rom_dy <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_emask <= w_emask_start;
                  r_dmask <= bus.ch_en;
                  r_dx_p0 <= '0;
                  r_dy_p0 <= '0;
                  if (|w_emask_start)  r_state <= S_ERASE;
                  else if (|bus.ch_en) r_state <= S_DRAW;
                  else                 r_state <= S_DRAIN;
               end
            end
            S_ERASE, S_DRAW: begin
               if (r_state == S_DRAW) begin
                  r_rom_ch <= w_ch;
                  r_rom_dx <= r_dx_p0;
                  r_rom_dy <= r_dy_p0;
               end
               if (!w_last_dx) begin
                  r_dx_p0 <= r_dx_p0 + S_W'(1);
               end else begin
                  r_dx_p0 <= '0;
                  if (!w_last_dy) begin
                     r_dy_p0 <= r_dy_p0 + S_W'(1);
                  end else begin
                     r_dy_p0 <= '0;
                     if (r_state == S_ERASE) r_emask <= w_mask_next;
                     else                    r_dmask <= w_mask_next;
                     if (w_mask_next == '0) begin
                        if (r_state == S_ERASE && (|r_dmask)) r_state <= S_DRAW;
                        else                                  r_state <= S_DRAIN;
                     end
                  end
               end
            end
            S_DRAIN:   r_state <= S_COLLIDE;
            S_COLLIDE: begin
               r_hit   <= w_hit;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_ovalid <= r_sen;
               r_state  <= S_IDLE;
            end
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // Snapshot at start; drawn boxes become the old boxes when the pass completes
   always_ff @(posedge clock) begin
      if (r_state == S_IDLE && bus.start) begin
         r_sen <= bus.ch_en;
         r_sx  <= bus.ch_x;
         r_sy  <= bus.ch_y;
         r_sw  <= bus.ch_w;
         r_sh  <= bus.ch_h;
      end
      if (r_state == S_DONE) begin
         r_ox <= r_sx;
         r_oy <= r_sy;
         r_ow <= r_sw;
         r_oh <= r_sh;
      end
   end

   // ---- stage p0 -> p1: draw pixel waits for its ROM colour
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_vld_p1 <= 1'b0;
      else         r_vld_p1 <= (r_state == S_DRAW) && w_on_screen;
   end

   // Draw pixel coordinates travelling alongside the ROM read
   always_ff @(posedge clock) begin
      r_x_p1 <= w_px[X_W-1:0];
      r_y_p1 <= w_py[Y_W-1:0];
   end

   // ---- stage p1 -> p2: pixel output register (erase pixels enter here directly)
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_plot_p2   <= 1'b0;
         r_x_p2      <= '0;
         r_y_p2      <= '0;
         r_colour_p2 <= '0;
      end else if (r_state == S_ERASE) begin
         r_plot_p2   <= w_on_screen;
         r_x_p2      <= w_px[X_W-1:0];
         r_y_p2      <= w_py[Y_W-1:0];
         r_colour_p2 <= BG_COLOUR;
      end else if (r_vld_p1) begin
         r_plot_p2   <= !(TRANSP_EN && (bus.rom_colour == TRANSP_COLOUR));
         r_x_p2      <= r_x_p1;
         r_y_p2      <= r_y_p1;
         r_colour_p2 <= bus.rom_colour;
      end else begin
         r_plot_p2   <= 1'b0;
      end
   end

   assign bus.rom_ch = (r_state == S_DRAW) ? w_ch    : r_rom_ch;
   assign bus.rom_dx = (r_state == S_DRAW) ? r_dx_p0 : r_rom_dx;
   assign bus.rom_dy = (r_state == S_DRAW) ? r_dy_p0 : r_rom_dy;
   assign bus.plot   = r_plot_p2;
   assign bus.x      = r_x_p2;
   assign bus.y      = r_y_p2;
   assign bus.colour = r_colour_p2;
   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = (r_state == S_DONE);
   assign bus.hit    = r_hit;

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite renderer between the game logic (car, pedestrians, further actors) and `vga_adapter`. On each `start` pulse it snapshots every channel's position and size, erases each moved or disabled sprite's previous box with the background colour, and redraws every enabled sprite from a shared synchronous sprite ROM, skipping transparent pixels and clipping off-screen pixels. At the end of each pass it registers pairwise bounding-box overlap flags.

## Interface
- `N_CH`, 2: sprite channels, 1–8.
- `X_W`, 9: x coordinate width.
- `Y_W`, 8: y coordinate width.
- `S_W`, 6: sprite size/offset field width.
- `SCREEN_W`, 320: pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 240: pixels with y ≥ SCREEN_H are clipped.
- `BG_COLOUR`, 3'b000: erase colour.
- `TRANSP_EN`, 1: enables transparent-colour skipping.
- `TRANSP_COLOUR`, 3'b101: ROM colour that is never plotted.

Ports:
- `clock`, in, 1: single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begins a pass; sampled only in IDLE.
- `ch_en`, in, N_CH: channel enabled.
- `ch_x`, in, N_CH*X_W: top-left x; channel i occupies bits [i*X_W +: X_W].
- `ch_y`, in, N_CH*Y_W: top-left y.
- `ch_w`, in, N_CH*S_W: width−1.
- `ch_h`, in, N_CH*S_W: height−1.
- `rom_ch`, out, 3: ROM channel select.
- `rom_dx`, out, S_W: ROM x offset.
- `rom_dy`, out, S_W: ROM y offset.
- `rom_colour`, in, 3: ROM data, valid the cycle after the address.
- `plot`, out, 1: pixel write strobe to VGA.
- `x`, out, X_W: pixel x.
- `y`, out, Y_W: pixel y.
- `colour`, out, 3: pixel colour.
- `busy`, out, 1: pass in progress.
- `done`, out, 1: one-cycle pulse at the end of a pass.
- `hit`, out, N_CH: bit i is set when channel i overlapped another enabled channel in the last pass.

## Operation
- States: IDLE, ERASE, DRAW, DRAIN, COLLIDE, DONE.
- **IDLE.** `start`=1 latches all ch_* inputs into the snapshot and moves to ERASE. A `start` asserted in any other state is ignored.
- **ERASE.** Runs over channels in ascending order. A channel is erased when `old_valid[i]` is set and either (snapshot position ≠ old position) or (`ch_en[i]`=0).
  - Raster scan over the old box: dx is the inner loop, dy the outer.
  - One pixel per cycle, colour BG_COLOUR, no ROM access.
  - Non-erased channels take 0 cycles.
- **DRAW.** Runs over every enabled channel in ascending order, raster scan, one ROM address per cycle.
  - The pixel is plotted one cycle after its colour arrives.
  - `plot` is suppressed when TRANSP_EN=1 and `rom_colour` = TRANSP_COLOUR.
- **Clipping.** x = base + dx and y = base + dy are computed at X_W+1 / Y_W+1 bits. Off-screen pixels still consume their cycle, with `plot`=0.
- **DRAIN.** One cycle that flushes the ROM pipeline.
- **COLLIDE.** Channels i ≠ j, both enabled, overlap when all of the following hold (compared at extended width, no wrap):
  - x_i ≤ x_j + w_j
  - x_j ≤ x_i + w_i
  - y_i ≤ y_j + h_j
  - y_j ≤ y_i + h_i

  `hit` is registered at the end of COLLIDE.
- **DONE.** `done`=1 for one cycle. The old positions are set to the snapshot, `old_valid` is set to `ch_en`, and the FSM returns to IDLE.
- **Reset.** All outputs are 0, `hit`=0, `old_valid`=0 and the FSM is in IDLE. A reset mid-pass abandons the pass. The next pass draws with no erase.

## Timing
- Cycle 0 is the clock edge where `start` is sampled.
- E = total erase pixels; D = total draw pixels, where a sprite contributes (w+1)(h+1).
- `busy`=1 in cycles 1 through E+D+3.
- Cycles 1..E are ERASE. Each erase pixel is visible on `plot`/`x`/`y`/`colour` in the cycle after it is scanned.
- Cycles E+1..E+D are DRAW.
  - A pixel addressed in cycle c has `rom_colour` valid in c+1.
  - That pixel is visible on `plot`/`x`/`y`/`colour` in c+2.
- Cycle E+D+1 is DRAIN. Cycle E+D+2 is COLLIDE, and the last draw pixel is visible here. `hit` updates at the end of E+D+2.
- Cycle E+D+3 is DONE (`done`=1). The earliest accepted next `start` is in cycle E+D+4.
- Throughput is at most one `plot` per cycle. `plot`=0 whenever the outputs are not carrying a pixel.
- `rom_ch`/`rom_dx`/`rom_dy` hold their last value outside DRAW.

## Test plan
- **Single sprite, first pass.** Reset; ch0 en at (10,20), w=h=1, ROM returns 3'b010; `start`. Expect: E=0, 4 plots at (10,20), (11,20), (10,21), (11,21) with colour 010; `done` in cycle 7; `hit`=0.
- **Moved sprite.** Repeat with ch0 at (12,20). Expect: 4 erase plots at the old box with colour 000 in cycles 2–5, then 4 draw plots at the new box; `done` in cycle 11.
- **Transparency.** ROM returns 3'b101 for dx=0. Expect no `plot` for those pixels, and the cycle count unchanged.
- **Collision.** ch0 at (10,20) 2x2, ch1 at (11,21) 2x2. Expect `hit`=2'b11 after the pass. Then move ch1 to (13,21): expect `hit`=2'b00.
- **Clipping.** ch0 at (319,239), w=h=1. Expect only the (319,239) pixel plotted; 4 draw cycles consumed.
- **Start while busy / reset mid-pass.**
  - `start` pulsed mid-DRAW: ignored, the pass length is unchanged.
  - `resetn` low mid-ERASE: `plot`/`busy`/`done`/`hit` go to 0 immediately. The next pass performs no erase.
